// File: rtl/rgb_pkg.sv
// Shared types and palette helpers for the RGB fade converter.
package rgb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } fade_state_t;

   localparam logic [2:0] BLACK   = 3'd0;
   localparam logic [2:0] BLUE    = 3'd1;
   localparam logic [2:0] GREEN   = 3'd2;
   localparam logic [2:0] CYAN    = 3'd3;
   localparam logic [2:0] RED     = 3'd4;
   localparam logic [2:0] MAGENTA = 3'd5;
   localparam logic [2:0] YELLOW  = 3'd6;
   localparam logic [2:0] WHITE   = 3'd7;

   localparam int MAX_CH_W = 16;

   // Channels are packed contiguously at a stride of ch_w, B in the low field;
   // the caller truncates the result to 3*ch_w bits.
   function automatic logic [3*MAX_CH_W-1:0] colour_to_target(input logic [2:0] colour,
                                                               input int ch_w);
      logic [3*MAX_CH_W-1:0] fs;
      logic [3*MAX_CH_W-1:0] tgt;
      fs  = (3*MAX_CH_W)'((64'd1 << ch_w) - 64'd1);
      tgt = '0;
      for (int i = 0; i < 3; i++) begin
         if (colour[i]) tgt = tgt | (fs << (i * ch_w));
      end
      return tgt;
   endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// One colour channel: holds its target and steps toward it on each tick.
module rgb_channel_ramp
   import rgb_pkg::*;
#(
   parameter int CH_W = 8,
   parameter int STEP = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            load_val,
   input  logic [CH_W-1:0] tgt,
   output logic [CH_W-1:0] ch,
   output logic            at_tgt
);

   localparam logic signed [CH_W:0] STEP_S = (CH_W+1)'(STEP);

   logic [CH_W-1:0] tgt_q;
   logic [CH_W-1:0] ch_next;

   // Move by the clamped distance; the one-bit-wider signed difference keeps
   // the step from ever crossing the target.
   function automatic logic [CH_W-1:0] ramp_step(input logic [CH_W-1:0] cur,
                                                 input logic [CH_W-1:0] dst);
      logic signed [CH_W:0] diff;
      logic signed [CH_W:0] mag;
      diff = $signed({1'b0, dst}) - $signed({1'b0, cur});
      mag  = diff[CH_W] ? -diff : diff;
      if (mag > STEP_S) mag = STEP_S;
      if (diff[CH_W]) return cur - mag[CH_W-1:0];
      return cur + mag[CH_W-1:0];
   endfunction

   assign ch_next = ramp_step(ch, tgt_q);
   // Looks one tick ahead so completion coincides with the final step.
   assign at_tgt  = (ch_next == tgt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         ch    <= '0;
         tgt_q <= '0;
      end else begin
         if (tick)     ch    <= ch_next;
         if (load_val) tgt_q <= tgt;
      end
   end

endmodule

// File: rtl/rgb_fade_converter.sv
// Colour index to RGB converter with a linear, prescaled fade between colours.
module rgb_fade_converter
   import rgb_pkg::*;
#(
   parameter int CH_W = 8,
   parameter int STEP = 16,
   parameter int DIV  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              load,
   input  logic [2:0]        colour,
   output logic [3*CH_W-1:0] rgb,
   output logic              busy,
   output logic              done
);

   localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   fade_state_t       state, state_n;
   logic [PW-1:0]     presc, presc_n;
   logic              done_n;
   logic              load_go;
   logic              tick;
   logic              same;
   logic [3*CH_W-1:0] tgt_new;
   logic [2:0]        at_tgt;

   assign tgt_new = (3*CH_W)'(colour_to_target(colour, CH_W));
   assign load_go = load & enable;
   assign tick    = enable && (state == FADE) && (presc == LAST);
   assign same    = (tgt_new == rgb);
   assign busy    = (state == FADE);

   for (genvar i = 0; i < 3; i++) begin : g_ch
      rgb_channel_ramp #(
         .CH_W (CH_W),
         .STEP (STEP)
      ) u_ramp (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .load_val (load_go),
         .tgt      (tgt_new[i*CH_W +: CH_W]),
         .ch       (rgb[i*CH_W +: CH_W]),
         .at_tgt   (at_tgt[i])
      );
   end

   // A load always wins over a same-edge completion; the ramp itself still
   // takes that edge's tick toward the old target.
   always_comb begin
      state_n = state;
      presc_n = presc;
      done_n  = 1'b0;
      if (enable) begin
         if (load) begin
            presc_n = '0;
            if (state == IDLE && same) begin
               done_n = 1'b1;
            end else begin
               state_n = FADE;
            end
         end else if (state == FADE) begin
            if (presc == LAST) begin
               presc_n = '0;
               if (&at_tgt) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               presc_n = presc + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         presc <= presc_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_rgb_fade_converter.sv
// Randomised scoreboard bench for rgb_fade_converter against a behavioural model.
module tb_rgb_fade_converter;
   import rgb_pkg::*;

   localparam int CH_W = 8;
   localparam int STEP = 16;
   localparam int DIV  = 4;
   localparam int FS   = (1 << CH_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        load = 1'b0;
   logic [2:0]  colour = 3'd0;
   logic [23:0] rgb;
   logic        busy;
   logic        done;

   logic        rst2 = 1'b1;
   logic        enable2 = 1'b1;
   logic        load2 = 1'b0;
   logic [2:0]  colour2 = 3'd0;
   logic [11:0] rgb2;
   logic        busy2;
   logic        done2;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_on = 1'b1;

   int          m_ch[3]  = '{0, 0, 0};
   int          m_tgt[3] = '{0, 0, 0};
   int          m_cnt = 0;
   bit          m_fade = 1'b0;
   bit          m_done = 1'b0;
   logic [23:0] q_exp[$];

   always #5 clk = ~clk;

   rgb_fade_converter #(.CH_W(CH_W), .STEP(STEP), .DIV(DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .load   (load),
      .colour (colour),
      .rgb    (rgb),
      .busy   (busy),
      .done   (done)
   );

   rgb_fade_converter #(.CH_W(4), .STEP(1), .DIV(1)) dut_small (
      .clk    (clk),
      .rst    (rst2),
      .enable (enable2),
      .load   (load2),
      .colour (colour2),
      .rgb    (rgb2),
      .busy   (busy2),
      .done   (done2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [23:0] m_rgb();
      return 24'((m_ch[0] << 16) | (m_ch[1] << 8) | m_ch[2]);
   endfunction

   // Reference: channels as integers, a cycle counter for ticks, and the
   // palette rule applied directly to the colour bits (R = bit 2).
   task automatic model_edge(input bit r, input bit e, input bit l, input logic [2:0] c);
      bit tick;
      bit reached;
      int d;
      if (r) begin
         for (int i = 0; i < 3; i++) begin
            m_ch[i]  = 0;
            m_tgt[i] = 0;
         end
         m_fade = 1'b0;
         m_cnt  = 0;
         m_done = 1'b0;
         return;
      end
      m_done = 1'b0;
      if (!e) return;
      tick = 1'b0;
      if (m_fade) begin
         tick  = (m_cnt == DIV - 1);
         m_cnt = tick ? 0 : m_cnt + 1;
      end
      if (tick) begin
         for (int i = 0; i < 3; i++) begin
            d = m_tgt[i] - m_ch[i];
            if (d > 0)      m_ch[i] += (d < STEP) ? d : STEP;
            else if (d < 0) m_ch[i] -= (-d < STEP) ? -d : STEP;
         end
      end
      reached = (m_ch[0] == m_tgt[0]) && (m_ch[1] == m_tgt[1]) && (m_ch[2] == m_tgt[2]);
      if (l) begin
         for (int i = 0; i < 3; i++) m_tgt[i] = c[2-i] ? FS : 0;
         if (m_fade) begin
            m_cnt = 0;
         end else if (m_ch[0] == m_tgt[0] && m_ch[1] == m_tgt[1] && m_ch[2] == m_tgt[2]) begin
            m_done = 1'b1;
         end else begin
            m_fade = 1'b1;
            m_cnt  = 0;
         end
      end else if (tick && reached) begin
         m_fade = 1'b0;
         m_done = 1'b1;
      end
      if (m_done) q_exp.push_back(m_rgb());
   endtask

   task automatic drive(input bit r, input bit e, input bit l, input logic [2:0] c);
      rst    = r;
      enable = e;
      load   = l;
      colour = c;
      @(posedge clk);
      model_edge(r, e, l, c);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 3'd0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check("rgb", rgb, m_rgb());
         check("busy", busy, m_fade);
         check("done", done, m_done);
         if (done) begin
            if (q_exp.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected_done at %0t: got done with rgb %h, expected none", $time, rgb);
            end else begin
               check("sb_final_rgb", rgb, q_exp.pop_front());
            end
         end
      end
   end

   initial begin
      // Reset held with load/enable high: nothing may start.
      drive(1'b1, 1'b1, 1'b1, WHITE);
      check("rst_rgb", rgb, 24'h000000);
      check("rst_busy", busy, 1'b0);
      drive(1'b1, 1'b1, 1'b1, WHITE);
      check("rst_done", done, 1'b0);

      // Fade up black -> white.
      drive(1'b0, 1'b1, 1'b1, WHITE);
      check("up_busy", busy, 1'b1);
      idle(4);
      check("up_tick1", rgb, 24'h101010);
      idle(28);
      check("up_tick8", rgb, 24'h808080);
      idle(32);
      check("up_final", rgb, 24'hFFFFFF);
      check("up_done", done, 1'b1);
      check("up_busy_end", busy, 1'b0);
      idle(1);
      check("up_done_clear", done, 1'b0);

      // Partial fade white -> cyan.
      drive(1'b0, 1'b1, 1'b1, CYAN);
      idle(3);
      check("cyan_pre", rgb, 24'hFFFFFF);
      idle(1);
      check("cyan_tick1", rgb, 24'hEFFFFF);
      idle(59);
      check("cyan_no_done", done, 1'b0);
      idle(1);
      check("cyan_final", rgb, 24'h00FFFF);
      check("cyan_done", done, 1'b1);

      // Freeze mid-tick for 10 cycles with ignored loads.
      drive(1'b1, 1'b1, 1'b0, BLACK);
      drive(1'b0, 1'b1, 1'b1, WHITE);
      idle(6);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, i[0], 3'($urandom_range(0, 7)));
         check("frz_rgb", rgb, 24'h101010);
         check("frz_done", done, 1'b0);
      end
      idle(1);
      check("frz_hold", rgb, 24'h101010);
      idle(1);
      check("frz_tick2", rgb, 24'h202020);
      idle(55);
      check("frz_not_yet", done, 1'b0);
      idle(1);
      check("frz_done_late", done, 1'b1);
      check("frz_final", rgb, 24'hFFFFFF);

      // Retarget to red on the tick that reaches 808080.
      drive(1'b1, 1'b1, 1'b0, BLACK);
      drive(1'b0, 1'b1, 1'b1, WHITE);
      idle(31);
      check("rt_pre", rgb, 24'h707070);
      drive(1'b0, 1'b1, 1'b1, RED);
      check("rt_mid", rgb, 24'h808080);
      check("rt_no_done", done, 1'b0);
      check("rt_busy", busy, 1'b1);
      idle(31);
      check("rt_not_yet", done, 1'b0);
      idle(1);
      check("rt_final", rgb, 24'hFF0000);
      check("rt_done", done, 1'b1);

      // Load of the current colour while idle.
      drive(1'b1, 1'b1, 1'b0, BLACK);
      drive(1'b0, 1'b1, 1'b1, BLACK);
      check("same_done", done, 1'b1);
      check("same_busy", busy, 1'b0);
      idle(1);
      check("same_done_clear", done, 1'b0);

      // Reset mid-fade aborts without done.
      drive(1'b0, 1'b1, 1'b1, WHITE);
      idle(10);
      drive(1'b1, 1'b1, 1'b0, BLACK);
      check("abort_rgb", rgb, 24'h000000);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      idle(70);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 24) == 0, 3'($urandom_range(0, 7)));
      end
      idle(80);
      check("sb_drained", q_exp.size(), 0);
      mon_on = 1'b0;

      // Small configuration: CH_W=4, STEP=1, DIV=1.
      @(posedge clk);
      #1;
      rst2    = 1'b0;
      load2   = 1'b1;
      colour2 = WHITE;
      @(posedge clk);
      #1;
      load2 = 1'b0;
      check("s_busy", busy2, 1'b1);
      check("s_rgb0", rgb2, 12'h000);
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         check("s_rgb", rgb2, 12'(k * 12'h111));
         check("s_done", done2, k == 15);
         check("s_busy_k", busy2, k < 15);
      end
      @(posedge clk);
      #1;
      check("s_done_clear", done2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_fade_converter.md
Name: rgb_fade_converter

Overview:
Parametrised successor to the 3-bit colour-to-RGB converter. It maps a 3-bit colour index to a packed RGB value with configurable channel width. Instead of switching instantly, it ramps each channel linearly from the current output to the new target, one step per prescaled tick. It sits between the colour-select logic and the LED/PWM driver and reports busy/done status.

Parameters:
CH_W, 8, bits per colour channel; full scale FS = 2^CH_W-1; legal range 1..16.
STEP, 16, per-tick channel increment/decrement; legal range 1..FS.
DIV, 4, clock cycles per ramp tick; legal range 1..65535.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  high = run; low = freeze all state and ignore load.
load  input  1  single-cycle request to fade to colour.
colour  input  3  palette index, sampled when load && enable.
rgb  output  3*CH_W  registered output {R,G,B}; R is the MSB field.
busy  output  1  high while a fade is in progress.
done  output  1  one-cycle pulse when the output reaches the target.

Behaviour:
- Palette mapping: bit2 drives R, bit1 drives G, bit0 drives B. Each channel target is FS if its bit is set, else 0.
  - 0=black, 1=blue, 2=green, 3=cyan, 4=red, 5=magenta, 6=yellow, 7=white.
  - At CH_W=8: 3 -> 00FFFF, 7 -> FFFFFF.
- Reset, sampled at the clock edge, clears everything on that edge: rgb=0, target=0, busy=0, done=0, prescaler=0, state=IDLE.
  - rst has priority over load and enable.
  - Reset mid-fade aborts the fade with no done pulse.
- States:
  - IDLE: load&&enable latches the target, clears the prescaler and moves to FADE. busy goes high on that edge.
  - FADE: while enable is high, the prescaler counts 0..DIV-1. A tick occurs on the edge where prescaler==DIV-1, and the prescaler then wraps to 0. DIV=1 gives a tick every cycle.
- Tick update, per channel: ch += min(STEP, tgt-ch) if ch<tgt; ch -= min(STEP, ch-tgt) if ch>tgt; unchanged if equal.
  - No overflow or underflow is possible; use CH_W+1-bit difference arithmetic.
  - Each channel moves independently.
- Completion: on the tick edge where all three channels equal the target, rgb takes the final value, state returns to IDLE, busy=0 and done=1 for exactly one cycle.
- Latency: the first tick lands DIV edges after the load edge. A 0->FS fade at the defaults takes ceil(255/16)=16 ticks, so done is asserted 64 edges after the load edge.
- Load in IDLE when the target equals the current rgb: state stays IDLE, done pulses on the next edge, busy stays low.
- Load during FADE (retarget): the new target is latched, the prescaler is cleared and the ramp continues from the current rgb. Load wins over a same-edge completion, so no done is produced for the abandoned target.
- enable low: rgb, prescaler, state and target all hold. load is ignored and done is forced low; a pending completion is deferred, not lost.

Decomposition:
- Package rgb_pkg contains:
  - the state enum (IDLE, FADE);
  - named colour index constants BLACK..WHITE;
  - the function colour_to_target(colour, CH_W).
- One sub-module, rgb_channel_ramp (params CH_W, STEP), instantiated 3x.
  - Inputs: clk, rst, tick, load_val, tgt.
  - Outputs: ch, at_tgt.
- The top level holds the FSM, the prescaler and the busy/done logic.

Test Plan:
1. Reset: hold rst for 2 cycles with load=1 and enable=1 -> rgb=000000, busy=0, done=0 every cycle; no fade starts.
2. Fade up: from black, load colour=7 at edge N (defaults) -> busy=1 after N; rgb=101010 after N+4 and 808080 after N+32; rgb=FFFFFF with a done pulse after N+64 and busy=0; done=0 after N+65.
3. Partial fade: from white, load colour=3 -> R steps FF, EF, ..., 0F, 00 over 16 ticks while G and B stay FF; final rgb=00FFFF with a single done pulse.
4. Freeze: during a 0->7 fade, drop enable for 10 cycles mid-tick -> rgb and prescaler are constant throughout, load pulses are ignored, and done arrives exactly 10 cycles late (N+74).
5. Retarget: fading 0->7, load colour=4 on the edge rgb becomes 808080 (tick 8) -> no done for white. G and B ramp down while R ramps up; rgb=FF0000 after 8 more ticks (32 cycles) with one done pulse.
6. Edge cases:
   - Load 0 while idle at black -> done pulse next cycle with busy=0.
   - rst mid-fade -> rgb=000000 on the next cycle with no done pulse.
   - CH_W=4, STEP=1, DIV=1, load 7 -> rgb=FFF and done after 15 edges.
